// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder with carry in and carry out.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout_c
);

    logic [CHUNK:0] c;

    // Ripple the carry through the chunk one bit at a time.
    always_comb begin
        c     = '0;
        sum_c = '0;
        c[0]  = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout_c = c[CHUNK];
    end

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: processes CHUNK bits per clock, WIDTH/CHUNK cycles per result.
// Optional macro ADDSUB_EN adds the sub port (a - b as a + ~b + 1).
module chunk_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK-1:0]   sum_c;
    logic               cout_c;
    logic               last_c;
    logic               msb_cin_c;
    logic [WIDTH-1:0]   b_in;
    logic               cin_in;

    // Operand conditioning at capture: subtraction becomes a + ~b + 1.
    always_comb begin
        b_in   = b;
        cin_in = cin;
`ifdef ADDSUB_EN
        if (sub) begin
            b_in   = ~b;
            cin_in = 1'b1;
        end
`endif
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a      (a_sh[CHUNK-1:0]),
        .b      (b_sh[CHUNK-1:0]),
        .cin    (carry),
        .sum_c  (sum_c),
        .cout_c (cout_c)
    );

    // Result assembly, last-chunk detect and carry into the MSB for overflow.
    always_comb begin
        last_c    = (cnt == CNT_W'(N - 1));
        res_nxt   = (res_sh >> CHUNK) | (WIDTH'(sum_c) << (WIDTH - CHUNK));
        msb_cin_c = sum_c[CHUNK-1] ^ a_sh[CHUNK-1] ^ b_sh[CHUNK-1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_c) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            s      <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_in;
                        carry <= cin_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    res_sh <= res_nxt;
                    carry  <= cout_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_c) begin
                        s    <= res_nxt;
                        cout <= cout_c;
                        ovf  <= msb_cin_c ^ cout_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/chunk_serial_adder.md
CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request to begin an addition; sampled on rising edge.
REQ-006 Port a  input  WIDTH  operand A, captured on accepted start.
REQ-007 Port b  input  WIDTH  operand B, captured on accepted start.
REQ-008 Port cin  input  1  carry-in, captured on accepted start.
REQ-009 Port sub  input  1  subtract select, captured on accepted start; present only when ADDSUB_EN is defined.
REQ-010 Port busy  output  1  high while an operation is in progress.
REQ-011 Port done  output  1  one-cycle pulse on completion.
REQ-012 Port s  output  WIDTH  registered sum, stable between completions.
REQ-013 Port cout  output  1  registered carry-out of bit WIDTH-1.
REQ-014 Port ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 The block SHALL implement states IDLE, RUN, DONE; N = WIDTH/CHUNK.
REQ-016 IDLE or DONE with start=1: capture a, b, cin (and sub), clear chunk counter, go to RUN; start in RUN SHALL be ignored.
REQ-017 RUN: each cycle add the least significant CHUNK bits of the operand shift registers plus the carry register, store the CHUNK result bits, shift operands right by CHUNK, update carry.
REQ-018 After the N-th RUN cycle, transfer the result to s, cout, ovf and go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then go to IDLE unless start=1 (back-to-back accepted).
REQ-020 Latency: start accepted at edge t -> done high in cycle t+N+1; throughput one result per N+1 cycles.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 s, cout, ovf SHALL change only on the RUN->DONE transition and on reset.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; {cout,s} = a + b + cin.
REQ-024 With CHUNK = WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, s=0, cout=0, ovf=0, counter and carry to 0, overriding start in the same cycle.
REQ-026 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-027 Macro ADDSUB_EN defined: sub port exists; sub=1 computes a + ~b + 1 (cin ignored), cout = NOT borrow, ovf per REQ-014.
REQ-028 Macro ADDSUB_EN undefined: sub port absent; block is add-only per REQ-023.

Structure
REQ-029 Shared package adder_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and default WIDTH/CHUNK constants.
REQ-030 The per-cycle adder SHALL be a sub-module chunk_adder (CHUNK-bit combinational ripple adder with carry in/out), instantiated once.

Verification
REQ-031 WIDTH=32, CHUNK=8: a=0x00800800, b=0x00020000, cin=0 -> s=0x00820800, cout=0, ovf=0, done 5 cycles after start edge.
REQ-032 a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, cout=1, ovf=0; a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, cout=0, ovf=1.
REQ-033 start pulsed again in RUN with different operands -> ignored; s matches first operands; next start in DONE accepted back-to-back.
REQ-034 rst asserted at 2nd RUN cycle -> busy=0 next cycle, s=0, no done pulse.
REQ-035 ADDSUB_EN, sub=1: a=5, b=7 -> s=0xFFFFFFFE, cout=0; a=7, b=5 -> s=0x00000002, cout=1.
REQ-036 WIDTH=32, CHUNK=32: a=0x00000001, b=0x00000002 -> s=0x00000003, done 2 cycles after start edge.
